pwls_channel_reg_file: RTL and testbench
========================================

// Module: pwls_channel_reg_file
// PURPOSE
//  Write-side register file feeding pwls_channel_ALU_unit: takes byte writes from the host bus into
//  per-channel shadow registers. It commits shadow->active at frame boundaries, so parameter changes
//  never tear mid-sample. Serves active fields of the channel picked by the channel sequencer, 1-cycle read latency.
// PARAMETERS
//  NUM_CHANNELS  4  channels held; power of two, 2..8
//  (field widths come from pwls_pkg and match ALU defaults: BITS=12, OCT=3, MANT=10, DETUNE_EXP=3, SLOPE_EXP=4)
// PORTS
//  clk           in   1                 clock
//  reset         in   1                 synchronous, active-high reset
//  wr_valid      in   1                 host write request
//  wr_ready      out  1                 write accepted when wr_valid&&wr_ready
//  wr_addr       in   CH_BITS+3         {channel, reg[2:0]}
//  wr_data       in   8                 write byte
//  frame_tick    in   1                 1-cycle pulse at sample-frame boundary
//  rd_ch         in   CH_BITS           channel selected by sequencer
//  mantissa      out  10                active fields of rd_ch, registered
//  octave        out  3
//  detune_exp    out  3
//  tri_offset    out  12
//  slope_exp     out  4
//  slope_offset  out  9
//  amp           out  10
//  channel_mode  out  CHANNEL_MODE_BITS
//  commit_overrun out 1                 sticky: frame_tick arrived during COMMIT
// BEHAVIOUR
//  Register map (per channel, byte regs):
//    0 mantissa[7:0]   1 {detune_exp,octave,mantissa[9:8]}   2 tri_offset[7:0]   3 {slope_exp,tri_offset[11:8]}
//    4 slope_offset[7:0]   5 {5'b0,amp[9:8],slope_offset[8]}   6 amp[7:0]   7 channel_mode (upper bits ignored)
//  Reset: all shadow/active regs 0 (amp=0 => silence), pending=0, FSM=IDLE, wr_ready=0 in reset cycle then 1,
//    all field outputs 0, commit_overrun=0.
//  Writes: accepted only in IDLE (wr_ready=1). Accepted write updates shadow byte the next edge.
//    Write to reg 7 additionally sets pending[ch]. Reserved bits are written as 0.
//  FSM IDLE: frame_tick && |pending -> COMMIT with ch_cnt=0; frame_tick with no pending stays IDLE.
//  FSM COMMIT: one channel per cycle; if pending[ch_cnt], copy shadow->active and clear pending[ch_cnt].
//    ch_cnt==NUM_CHANNELS-1 -> IDLE. The state lasts exactly NUM_CHANNELS cycles; wr_ready=0 throughout.
//  Same-cycle write and frame_tick in IDLE: the write lands in shadow and sets pending, but the commit
//    starts from the next cycle, so it sees the new value (commit reads shadow while in COMMIT).
//  frame_tick during COMMIT: ignored, commit_overrun<=1 (cleared only by reset).
//  Read: field outputs <= active[rd_ch] each cycle (1-cycle latency). A channel committed in cycle N
//    is visible on outputs from cycle N+2.
//  Reset asserted mid-COMMIT: aborts; all state returns to reset values; partial commits are discarded.
//  Address wrap: none. Every wr_addr value maps to a register.
// CONFIGURATION
//  PWLS_REG_READBACK_EN: adds rd_req in 1 and rd_addr in CH_BITS+3. Adds rd_data out 8, which returns
//    shadow byte at rd_addr the cycle after rd_req (reserved bits 0), plus the rd_data_valid out 1 pulse.
//    Readback is allowed in any FSM state. Undefined: ports absent, no readback logic.
// STRUCTURE
//  pwls_pkg: field width localparams, REG_* offsets, channel_param_t packed struct (all ALU fields),
//    reg_state_e {IDLE, COMMIT}.
//  Sub-module pwls_param_pack: combinational byte-map <-> channel_param_t (write merge + readback mux).
//  Shadow/active arrays are channel_param_t [NUM_CHANNELS].
// TESTING
//  1. Reset, then hold rd_ch=0..3 -> all fields 0, wr_ready=1 from first post-reset cycle, overrun=0.
//  2. Write ch1 reg0=0x34, reg1=0x5E, reg7=0x02, then frame_tick -> wr_ready low 4 cycles.
//     rd_ch=1 then gives mantissa=0x234, octave=7, detune_exp=2, channel_mode=2.
//  3. Write ch2 regs 0..6 without reg7, then frame_tick -> no COMMIT and no ready drop; ch2 active unchanged.
//  4. Second frame_tick 2 cycles into COMMIT -> commit_overrun=1 and stays 1; commit still ends after 4 cycles.
//  5. Write ch3 reg7 and frame_tick in the same cycle -> COMMIT next cycle; ch3 channel_mode updated.
//  6. Reset during COMMIT cycle 1 after ch0 written -> all outputs 0, pending cleared, ch0 active 0.

Source files
------------

// File: rtl/pwls_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwls_pkg
//  Description : Shared field widths, register offsets, channel parameter
//                record and register-file state encoding for the PWLS
//                channel register file and ALU.
//  Revision    : 1.0  initial release
// ============================================================================
package pwls_pkg;

  // Field widths (match the ALU defaults)
  localparam int BITS              = 12;
  localparam int OCT_BITS          = 3;
  localparam int MANT_BITS         = 10;
  localparam int DETUNE_EXP_BITS   = 3;
  localparam int SLOPE_EXP_BITS    = 4;
  localparam int SLOPE_OFFSET_BITS = 9;
  localparam int AMP_BITS          = 10;
  localparam int CHANNEL_MODE_BITS = 2;

  // Per-channel byte register offsets
  localparam logic [2:0] REG_MANT_LO  = 3'd0;  // mantissa[7:0]
  localparam logic [2:0] REG_MANT_HI  = 3'd1;  // {detune_exp, octave, mantissa[9:8]}
  localparam logic [2:0] REG_TRI_LO   = 3'd2;  // tri_offset[7:0]
  localparam logic [2:0] REG_TRI_HI   = 3'd3;  // {slope_exp, tri_offset[11:8]}
  localparam logic [2:0] REG_SLOPE_LO = 3'd4;  // slope_offset[7:0]
  localparam logic [2:0] REG_AMP_HI   = 3'd5;  // {5'b0, amp[9:8], slope_offset[8]}
  localparam logic [2:0] REG_AMP_LO   = 3'd6;  // amp[7:0]
  localparam logic [2:0] REG_MODE     = 3'd7;  // channel_mode, also arms commit

  // Every parameter the ALU consumes for one channel
  typedef struct packed {
    logic [MANT_BITS-1:0]         mantissa;
    logic [OCT_BITS-1:0]          octave;
    logic [DETUNE_EXP_BITS-1:0]   detune_exp;
    logic [BITS-1:0]              tri_offset;
    logic [SLOPE_EXP_BITS-1:0]    slope_exp;
    logic [SLOPE_OFFSET_BITS-1:0] slope_offset;
    logic [AMP_BITS-1:0]          amp;
    logic [CHANNEL_MODE_BITS-1:0] channel_mode;
  } channel_param_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } reg_state_e;

endpackage
`default_nettype wire

// File: rtl/pwls_param_pack.sv
`default_nettype none
// ============================================================================
//  Module      : pwls_param_pack
//  Description : Combinational byte map <-> channel_param_t. Merges one host
//                byte into a channel record; with PWLS_REG_READBACK_EN it also
//                extracts a byte from a record (reserved bits read as 0).
//  Revision    : 1.0  initial release
// ============================================================================
module pwls_param_pack
  import pwls_pkg::*;
(
  input  channel_param_t wr_cur,
  input  logic [2:0]     wr_reg,
  input  logic [7:0]     wr_byte,
  output channel_param_t wr_next
`ifdef PWLS_REG_READBACK_EN
  ,
  input  channel_param_t rd_cur,
  input  logic [2:0]     rd_reg,
  output logic [7:0]     rd_byte
`endif
);

  // Replace only the fields covered by the addressed byte register
  always_comb begin
    wr_next = wr_cur;
    case (wr_reg)
      REG_MANT_LO:  wr_next.mantissa[7:0] = wr_byte;
      REG_MANT_HI:  {wr_next.detune_exp, wr_next.octave, wr_next.mantissa[9:8]} = wr_byte;
      REG_TRI_LO:   wr_next.tri_offset[7:0] = wr_byte;
      REG_TRI_HI:   {wr_next.slope_exp, wr_next.tri_offset[11:8]} = wr_byte;
      REG_SLOPE_LO: wr_next.slope_offset[7:0] = wr_byte;
      REG_AMP_HI:   {wr_next.amp[9:8], wr_next.slope_offset[8]} = wr_byte[2:0];
      REG_AMP_LO:   wr_next.amp[7:0] = wr_byte;
      REG_MODE:     wr_next.channel_mode = wr_byte[CHANNEL_MODE_BITS-1:0];
      default:      wr_next = wr_cur;
    endcase
  end

`ifdef PWLS_REG_READBACK_EN
  // Rebuild the host-visible byte; bits with no backing field return 0
  always_comb begin
    rd_byte = 8'h00;
    case (rd_reg)
      REG_MANT_LO:  rd_byte = rd_cur.mantissa[7:0];
      REG_MANT_HI:  rd_byte = {rd_cur.detune_exp, rd_cur.octave, rd_cur.mantissa[9:8]};
      REG_TRI_LO:   rd_byte = rd_cur.tri_offset[7:0];
      REG_TRI_HI:   rd_byte = {rd_cur.slope_exp, rd_cur.tri_offset[11:8]};
      REG_SLOPE_LO: rd_byte = rd_cur.slope_offset[7:0];
      REG_AMP_HI:   rd_byte = {5'b00000, rd_cur.amp[9:8], rd_cur.slope_offset[8]};
      REG_AMP_LO:   rd_byte = rd_cur.amp[7:0];
      REG_MODE:     rd_byte = {{(8-CHANNEL_MODE_BITS){1'b0}}, rd_cur.channel_mode};
      default:      rd_byte = 8'h00;
    endcase
  end
`endif

endmodule
`default_nettype wire

// File: rtl/pwls_channel_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : pwls_channel_reg_file
//  Description : Host-writable per-channel shadow registers that are copied
//                to active registers only at frame boundaries, so a channel's
//                parameters never change mid-sample. Serves the active record
//                of the sequencer-selected channel with one cycle of latency.
//                Optional feature macro: PWLS_REG_READBACK_EN (shadow readback).
//  Revision    : 1.0  initial release
// ============================================================================
module pwls_channel_reg_file
  import pwls_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  localparam int CH_BITS = $clog2(NUM_CHANNELS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [CH_BITS+2:0]           wr_addr,
  input  logic [7:0]                   wr_data,
  input  logic                         frame_tick,
  input  logic [CH_BITS-1:0]           rd_ch,
  output logic [MANT_BITS-1:0]         mantissa,
  output logic [OCT_BITS-1:0]          octave,
  output logic [DETUNE_EXP_BITS-1:0]   detune_exp,
  output logic [BITS-1:0]              tri_offset,
  output logic [SLOPE_EXP_BITS-1:0]    slope_exp,
  output logic [SLOPE_OFFSET_BITS-1:0] slope_offset,
  output logic [AMP_BITS-1:0]          amp,
  output logic [CHANNEL_MODE_BITS-1:0] channel_mode,
  output logic                         commit_overrun
`ifdef PWLS_REG_READBACK_EN
  ,
  input  logic                         rd_req,
  input  logic [CH_BITS+2:0]           rd_addr,
  output logic [7:0]                   rd_data,
  output logic                         rd_data_valid
`endif
);

  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CHANNELS - 1);

  reg_state_e              state;
  logic [CH_BITS-1:0]      ch_cnt;
  logic [NUM_CHANNELS-1:0] pending;
  channel_param_t          shadow [NUM_CHANNELS];
  channel_param_t          active [NUM_CHANNELS];
  channel_param_t          out_q;

  logic [CH_BITS-1:0]      wr_ch;
  logic [2:0]              wr_reg;
  logic                    wr_fire;
  channel_param_t          wr_merged;
  logic [NUM_CHANNELS-1:0] wr_pend_set;

  assign wr_ch   = wr_addr[CH_BITS+2:3];
  assign wr_reg  = wr_addr[2:0];
  assign wr_fire = wr_valid && wr_ready;

`ifdef PWLS_REG_READBACK_EN
  logic [CH_BITS-1:0] rb_ch;
  logic [2:0]         rb_reg;
  logic [7:0]         rb_byte;

  assign rb_ch  = rd_addr[CH_BITS+2:3];
  assign rb_reg = rd_addr[2:0];

  pwls_param_pack u_pack (
    .wr_cur  (shadow[wr_ch]),
    .wr_reg  (wr_reg),
    .wr_byte (wr_data),
    .wr_next (wr_merged),
    .rd_cur  (shadow[rb_ch]),
    .rd_reg  (rb_reg),
    .rd_byte (rb_byte)
  );
`else
  pwls_param_pack u_pack (
    .wr_cur  (shadow[wr_ch]),
    .wr_reg  (wr_reg),
    .wr_byte (wr_data),
    .wr_next (wr_merged)
  );
`endif

  // Mode-register writes arm the channel for the next frame commit
  always_comb begin
    wr_pend_set = '0;
    if (wr_fire && (wr_reg == REG_MODE)) begin
      wr_pend_set[wr_ch] = 1'b1;
    end
  end

  // Shadow writes, pending flags and the frame-boundary commit sequencer.
  // A write arriving with frame_tick is folded into the go decision so the
  // same frame already commits it; the sweep reads shadow during COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ch_cnt         <= '0;
      pending        <= '0;
      wr_ready       <= 1'b0;
      commit_overrun <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (wr_fire) begin
            shadow[wr_ch] <= wr_merged;
          end
          pending <= pending | wr_pend_set;
          if (frame_tick && (|(pending | wr_pend_set))) begin
            state    <= COMMIT;
            ch_cnt   <= '0;
            wr_ready <= 1'b0;
          end else begin
            wr_ready <= 1'b1;
          end
        end
        COMMIT: begin
          if (pending[ch_cnt]) begin
            active[ch_cnt]  <= shadow[ch_cnt];
            pending[ch_cnt] <= 1'b0;
          end
          if (frame_tick) begin
            commit_overrun <= 1'b1;
          end
          if (ch_cnt == LAST_CH) begin
            state    <= IDLE;
            wr_ready <= 1'b1;
          end else begin
            ch_cnt <= ch_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          wr_ready <= 1'b0;
        end
      endcase
    end
  end

  // Register the active record of the sequencer's channel
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= active[rd_ch];
    end
  end

  assign mantissa     = out_q.mantissa;
  assign octave       = out_q.octave;
  assign detune_exp   = out_q.detune_exp;
  assign tri_offset   = out_q.tri_offset;
  assign slope_exp    = out_q.slope_exp;
  assign slope_offset = out_q.slope_offset;
  assign amp          = out_q.amp;
  assign channel_mode = out_q.channel_mode;

`ifdef PWLS_REG_READBACK_EN
  // Shadow readback, one cycle after the request, in any FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data       <= 8'h00;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_req;
      if (rd_req) begin
        rd_data <= rb_byte;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwls_channel_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwls_channel_reg_file
//  Description : Scoreboard bench for pwls_channel_reg_file. A byte-level
//                reference model predicts each cycle's outputs; a monitor
//                compares them against the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pwls_channel_reg_file;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        frame_tick;
  logic [1:0]  rd_ch;
  logic [9:0]  mantissa;
  logic [2:0]  octave;
  logic [2:0]  detune_exp;
  logic [11:0] tri_offset;
  logic [3:0]  slope_exp;
  logic [8:0]  slope_offset;
  logic [9:0]  amp;
  logic [1:0]  channel_mode;
  logic        commit_overrun;
`ifdef PWLS_REG_READBACK_EN
  logic        rd_req = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [7:0]  rd_data;
  logic        rd_data_valid;
`endif

  always #5 clk = ~clk;

  pwls_channel_reg_file #(.NUM_CHANNELS(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .frame_tick     (frame_tick),
    .rd_ch          (rd_ch),
    .mantissa       (mantissa),
    .octave         (octave),
    .detune_exp     (detune_exp),
    .tri_offset     (tri_offset),
    .slope_exp      (slope_exp),
    .slope_offset   (slope_offset),
    .amp            (amp),
    .channel_mode   (channel_mode),
    .commit_overrun (commit_overrun)
`ifdef PWLS_REG_READBACK_EN
    ,
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_data_valid  (rd_data_valid)
`endif
  );

  typedef struct packed {
    logic        ready;
    logic [52:0] fields;
    logic        ovr;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: registers kept as host-visible bytes
  int sh  [N][8];
  int act [N][8];
  bit [N-1:0] pend;
  int  cidx;      // -1 when not committing, else channel being committed
  bit  m_ready;
  bit  m_ovr;

  function automatic int reg_mask(input int r);
    if (r == 5) return 32'h07;
    if (r == 7) return 32'h03;
    return 32'hFF;
  endfunction

  function automatic logic [52:0] fields_of(input int c);
    int b[8];
    for (int r = 0; r < 8; r++) b[r] = act[c][r];
    return {10'(b[0] + (b[1] % 4) * 256),
            3'((b[1] / 4) % 8),
            3'(b[1] / 32),
            12'(b[2] + (b[3] % 16) * 256),
            4'(b[3] / 16),
            9'(b[4] + (b[5] % 2) * 256),
            10'(b[6] + ((b[5] / 2) % 4) * 256),
            2'(b[7])};
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // One clock cycle of stimulus plus the model's prediction for it
  task automatic cyc(input bit rst, input bit wv, input int addr, input int data,
                     input bit tk, input int rc);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    wr_valid   = wv;
    wr_addr    = 5'(addr);
    wr_data    = 8'(data);
    frame_tick = tk;
    rd_ch      = 2'(rc);
    if (rst) begin
      for (int c = 0; c < N; c++)
        for (int r = 0; r < 8; r++) begin sh[c][r] = 0; act[c][r] = 0; end
      pend = '0; cidx = -1; m_ready = 0; m_ovr = 0;
      e = '0;
    end else begin
      e.fields = fields_of(rc);
      if (cidx >= 0) begin
        if (pend[cidx]) begin
          for (int r = 0; r < 8; r++) act[cidx][r] = sh[cidx][r];
          pend[cidx] = 1'b0;
        end
        if (tk) m_ovr = 1;
        cidx++;
        if (cidx == N) cidx = -1;
      end else begin
        if (wv && m_ready) begin
          sh[addr / 8][addr % 8] = data & reg_mask(addr % 8);
          if (addr % 8 == 7) pend[addr / 8] = 1'b1;
        end
        if (tk && pend != '0) cidx = 0;
      end
      m_ready = (cidx < 0);
      e.ready = m_ready;
      e.ovr   = m_ovr;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n, input int rc);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rc);
  endtask

  task automatic wr(input int ch, input int r, input int d, input int rc);
    cyc(0, 1, ch * 8 + r, d, 0, rc);
  endtask

  task automatic sample;
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every registered output cycle against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wr_ready", 64'(wr_ready), 64'(e.ready));
        chk("fields", 64'({mantissa, octave, detune_exp, tri_offset, slope_exp,
                           slope_offset, amp, channel_mode}), 64'(e.fields));
        chk("commit_overrun", 64'(commit_overrun), 64'(e.ovr));
      end
    end
  end

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    frame_tick = 1'b0; rd_ch = '0;

    // 1: reset, then sweep rd_ch with everything zero
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < N; c++) idle(1, c);
    sample;
    chk("reset_ready", 64'(wr_ready), 64'd1);
    chk("reset_amp", 64'(amp), 64'd0);

    // 2: ch1 mantissa/octave/detune/mode, committed on a frame tick
    wr(1, 0, 8'h34, 1);
    wr(1, 1, 8'h5E, 1);
    wr(1, 7, 8'h02, 1);
    cyc(0, 0, 0, 0, 1, 1);
    sample;
    chk("commit_ready_low", 64'(wr_ready), 64'd0);
    idle(6, 1);
    sample;
    chk("t2_mantissa", 64'(mantissa), 64'h234);
    chk("t2_octave", 64'(octave), 64'd7);
    chk("t2_detune", 64'(detune_exp), 64'd2);
    chk("t2_mode", 64'(channel_mode), 64'd2);

    // 3: ch2 regs 0..6 without the mode register -> no commit
    for (int r = 0; r < 7; r++) wr(2, r, $urandom_range(1, 255), 2);
    cyc(0, 0, 0, 0, 1, 2);
    sample;
    chk("no_commit_ready", 64'(wr_ready), 64'd1);
    idle(3, 2);
    sample;
    chk("t3_ch2_amp", 64'(amp), 64'd0);

    // 4: second frame tick two cycles into a commit
    wr(0, 7, 8'h01, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(6, 0);
    sample;
    chk("t4_overrun", 64'(commit_overrun), 64'd1);

    // 5: mode write coincident with frame tick
    cyc(0, 1, 3 * 8 + 7, 8'hFF, 1, 3);
    sample;
    chk("t5_ready_low", 64'(wr_ready), 64'd0);
    idle(6, 3);
    sample;
    chk("t5_mode", 64'(channel_mode), 64'd3);

    // 6: reset lands on the first commit cycle
    wr(0, 0, 8'h55, 0);
    wr(0, 7, 8'h02, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(6, 0);
    sample;
    chk("t6_mantissa", 64'(mantissa), 64'd0);
    chk("t6_overrun", 64'(commit_overrun), 64'd0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 1) == 1),
          int'($urandom_range(0, 31)),
          int'($urandom_range(0, 255)),
          ($urandom_range(0, 5) == 0),
          int'($urandom_range(0, N - 1)));
    end
    idle(2, 0);
    sample;
    sample;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
